// File: rtl/camera_module_debug_mem_arbiter.sv
// Arbiter/sequencer for the 256 x 32 debug RAM. Shares one RAM port between
// the JTAG command path (single pending slot, auto-incrementing pointer) and
// the CPU-side Avalon debug slave, with round-robin arbitration on contention.
module camera_module_debug_mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic [37:0] jdo,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        jtag_overrun,
  input  logic [7:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [7:0]  ram_addr,
  output logic        ram_wren,
  output logic [3:0]  ram_byteen,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  typedef enum logic {GRANT_JTAG, GRANT_AVS} grant_t;

  state_t      state, state_next;
  grant_t      last_grant, owner;

  // JTAG pointer and single pending slot
  logic [7:0]  pointer;
  logic        pend_valid;
  logic        pend_write;
  logic [7:0]  pend_addr;
  logic [31:0] pend_data;

  // Operation latched at grant time, replayed on the RAM port in ISSUE
  logic        op_write;
  logic [7:0]  op_addr;
  logic [31:0] op_data;
  logic [3:0]  op_byteen;

  logic        jtag_req, avs_req, grant_jtag, start_op;
  logic        jtag_issuing, any_strobe, strobe_accept, queue_op;
  logic [7:0]  base_ptr, new_ptr;

  // Request, grant and strobe-acceptance decode
  always_comb begin
    jtag_req      = pend_valid;
    avs_req       = avs_read | avs_write;
    start_op      = (state == IDLE) && (jtag_req || avs_req);
    // Round-robin: JTAG wins a tie only when AVS was granted last.
    grant_jtag    = jtag_req && (!avs_req || (last_grant == GRANT_AVS));
    jtag_issuing  = (state == ISSUE) && (owner == GRANT_JTAG);
    any_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    // The slot frees up in the same cycle its op issues, so a strobe then is safe.
    strobe_accept = any_strobe && (!pend_valid || jtag_issuing);
    // A strobe arriving as the previous op issues must see the post-increment pointer.
    base_ptr      = jtag_issuing ? pointer + 8'd1 : pointer;
    new_ptr       = take_action_ocimem_a ? jdo[17:10] : base_ptr;
    queue_op      = (take_action_ocimem_a && jdo[34]) || take_action_ocimem_b ||
                    take_no_action_ocimem_a;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and RAM/Avalon port outputs
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next      = state;
    ram_addr        = 8'h00;
    ram_wren        = 1'b0;
    ram_byteen      = 4'h0;
    ram_wdata       = 32'h0;
    avs_waitrequest = 1'b1;
    avs_readdata    = 32'h0;
    monitor_ready   = !pend_valid && !((state != IDLE) && (owner == GRANT_JTAG));

    case (state)
      IDLE:    if (jtag_req || avs_req) state_next = ISSUE;
      ISSUE:   state_next = op_write ? IDLE : RDWAIT;
      RDWAIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // NOTE: the reset is synchronous, so the state register still holds the
    // abandoned op during the reset cycle; port drives are gated here to keep
    // a RAM write or Avalon completion from escaping in that cycle.
    if (reset_n) begin
      if (state == ISSUE) begin
        ram_addr   = op_addr;
        ram_byteen = op_byteen;
        ram_wdata  = op_data;
        ram_wren   = op_write;
        if (owner == GRANT_AVS && op_write) avs_waitrequest = 1'b0;
      end else if (state == RDWAIT && owner == GRANT_AVS) begin
        avs_waitrequest = 1'b0;
        avs_readdata    = ram_rdata;
      end
    end
  end

  // Grant latch, JTAG pointer/slot, overrun flag and JTAG read-data register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant   <= GRANT_AVS;
      owner        <= GRANT_AVS;
      op_write     <= 1'b0;
      op_addr      <= 8'h00;
      op_data      <= 32'h0;
      op_byteen    <= 4'h0;
      pointer      <= 8'h00;
      pend_valid   <= 1'b0;
      pend_write   <= 1'b0;
      pend_addr    <= 8'h00;
      pend_data    <= 32'h0;
      jtag_overrun <= 1'b0;
      MonDReg      <= 32'h0;
    end else begin
      if (start_op) begin
        if (grant_jtag) begin
          owner      <= GRANT_JTAG;
          last_grant <= GRANT_JTAG;
          op_write   <= pend_write;
          op_addr    <= pend_addr;
          op_data    <= pend_data;
          op_byteen  <= 4'hF;
        end else begin
          owner      <= GRANT_AVS;
          last_grant <= GRANT_AVS;
          // Simultaneous read and write from the Avalon side is a write.
          op_write   <= avs_write;
          op_addr    <= avs_address;
          op_data    <= avs_writedata;
          op_byteen  <= avs_write ? avs_byteenable : 4'hF;
        end
      end

      if (jtag_issuing) begin
        pend_valid <= 1'b0;
        pointer    <= pointer + 8'd1;
      end

      // An accepted strobe overrides the issue-time clear/increment above.
      if (strobe_accept) begin
        pointer    <= new_ptr;
        pend_valid <= queue_op;
        pend_write <= take_action_ocimem_b;
        pend_addr  <= new_ptr;
        pend_data  <= jdo[34:3];
        if (take_action_ocimem_a && jdo[35]) jtag_overrun <= 1'b0;
      end else if (any_strobe) begin
        jtag_overrun <= 1'b1;
      end

      if (state == RDWAIT && owner == GRANT_JTAG) MonDReg <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_camera_module_debug_mem_arbiter.sv
// Directed bench for camera_module_debug_mem_arbiter with a behavioural debug
// RAM and scoreboard queues for RAM writes, Avalon reads and JTAG reads.
module tb_camera_module_debug_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad   = 0;
  int n;

  // Scoreboards: RAM writes {addr, byteen, data}, Avalon read data, JTAG read data
  logic [43:0] wq[$];
  logic [31:0] aq[$];
  logic [31:0] jq[$];

  logic [31:0] mem [256] = '{default: '0};

  localparam int K_A  = 0;
  localparam int K_B  = 1;
  localparam int K_NA = 2;

  camera_module_debug_mem_arbiter dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .jdo                    (jdo),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .jtag_overrun           (jtag_overrun),
    .avs_address            (avs_address),
    .avs_read               (avs_read),
    .avs_write              (avs_write),
    .avs_writedata          (avs_writedata),
    .avs_byteenable         (avs_byteenable),
    .avs_readdata           (avs_readdata),
    .avs_waitrequest        (avs_waitrequest),
    .ram_addr               (ram_addr),
    .ram_wren               (ram_wren),
    .ram_byteen             (ram_byteen),
    .ram_wdata              (ram_wdata),
    .ram_rdata              (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: byte-lane writes, one-cycle read latency
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every RAM write must match the next expected write, in order
  always @(negedge clk) begin
    #2;
    if (ram_wren === 1'b1) begin
      if (wq.size() == 0) check("unexpected_ram_write", 64'(ram_wren), 64'd0);
      else check("ram_write", 64'({ram_addr, ram_byteen, ram_wdata}), 64'(wq.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [37:0] jdo_ptr(input logic [7:0] p, input logic rd, input logic clr);
    return {2'b00, clr, rd, 16'h0000, p, 10'h000};
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  task automatic strobe(input int kind, input logic [37:0] payload);
    jdo                     = payload;
    take_action_ocimem_a    = (kind == K_A);
    take_action_ocimem_b    = (kind == K_B);
    take_no_action_ocimem_a = (kind == K_NA);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (monitor_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check(tag, 64'(monitor_ready), 64'd1);
  endtask

  task automatic avs_wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    int k = 0;
    wq.push_back({a, be, d});
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    check({tag, "_wait_c0"}, 64'(avs_waitrequest), 64'd1);
    do begin tick(); k++; end while (avs_waitrequest !== 1'b0 && k < 20);
    check({tag, "_latency"}, 64'(k), 64'd1);
    avs_write = 1'b0;
    tick();
    check({tag, "_wait_after"}, 64'(avs_waitrequest), 64'd1);
  endtask

  task automatic avs_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    int k = 0;
    aq.push_back(exp);
    avs_address = a; avs_read = 1'b1;
    do begin tick(); k++; end while (avs_waitrequest !== 1'b0 && k < 20);
    check({tag, "_latency"}, 64'(k), 64'd2);
    check({tag, "_data"}, 64'(avs_readdata), 64'(aq.pop_front()));
    avs_read = 1'b0;
    tick();
    check({tag, "_rdata_idle"}, 64'(avs_readdata), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mondreg"}, 64'(MonDReg), 64'd0);
    check({tag, "_ready"}, 64'(monitor_ready), 64'd1);
    check({tag, "_overrun"}, 64'(jtag_overrun), 64'd0);
    check({tag, "_ram_port"}, 64'({ram_wren, ram_addr, ram_byteen, ram_wdata}), 64'd0);
    check({tag, "_waitreq"}, 64'(avs_waitrequest), 64'd1);
    check({tag, "_rdata"}, 64'(avs_readdata), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;

    // Power-on reset
    tick(); tick();
    check_reset_values("por");
    reset_n = 1'b1;
    tick();

    // JTAG writes around the pointer wrap, then read back with auto-increment
    strobe(K_A, jdo_ptr(8'hFE, 1'b0, 1'b0));
    wq.push_back({8'hFE, 4'hF, 32'hA5A5_0001});
    strobe(K_B, jdo_data(32'hA5A5_0001));
    check("jtag_busy", 64'(monitor_ready), 64'd0);
    wait_ready("jtag_wr1_ready");
    wq.push_back({8'hFF, 4'hF, 32'hA5A5_0002});
    strobe(K_B, jdo_data(32'hA5A5_0002));
    wait_ready("jtag_wr2_ready");
    wq.push_back({8'h00, 4'hF, 32'hC0DE_0003});   // lands at 0x00: pointer wrapped
    strobe(K_B, jdo_data(32'hC0DE_0003));
    wait_ready("jtag_wr3_ready");

    jq.push_back(32'hA5A5_0001);
    strobe(K_A, jdo_ptr(8'hFE, 1'b1, 1'b0));
    tick(); tick();
    check("mondreg_not_yet", 64'(MonDReg), 64'd0);
    tick();
    check("mondreg_cycle4", 64'(MonDReg), 64'(jq.pop_front()));
    check("ready_after_rd", 64'(monitor_ready), 64'd1);
    jq.push_back(32'hA5A5_0002);
    strobe(K_NA, '0);
    wait_ready("jtag_rd2_ready");
    check("mondreg_autoinc", 64'(MonDReg), 64'(jq.pop_front()));

    // Avalon latency and byte lanes
    avs_wr("avs_wr10", 8'h10, 32'h1234_5678, 4'b0011);
    avs_rd("avs_rd10", 8'h10, 32'h0000_5678);

    // Tie from reset: JTAG wins first, AVS completes after the JTAG read
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    jq.push_back(32'hC0DE_0003);
    aq.push_back(32'h0000_5678);
    strobe(K_NA, '0);
    avs_address = 8'h10; avs_read = 1'b1;
    n = 0;
    while (avs_waitrequest !== 1'b0 && n < 20) begin tick(); n++; end
    check("arb_avs_second_latency", 64'(n), 64'd5);
    check("arb_avs_data", 64'(avs_readdata), 64'(aq.pop_front()));
    check("arb_jtag_done_first", 64'(monitor_ready), 64'd1);
    check("arb_jtag_data", 64'(MonDReg), 64'(jq.pop_front()));
    avs_read = 1'b0;
    tick();

    // Sustained contention: order J,A,J,A; second JTAG strobe lands on the
    // first one's ISSUE cycle and must be accepted without overrun
    strobe(K_A, jdo_ptr(8'h40, 1'b0, 1'b0));
    wq.push_back({8'h40, 4'hF, 32'h1111_0001});
    strobe(K_B, jdo_data(32'h1111_0001));                  // now in cycle 1
    wq.push_back({8'h20, 4'hF, 32'h2222_0001});
    avs_address = 8'h20; avs_writedata = 32'h2222_0001; avs_byteenable = 4'hF; avs_write = 1'b1;
    tick();                                                // cycle 2: ISSUE J1
    wq.push_back({8'h41, 4'hF, 32'h1111_0002});
    strobe(K_B, jdo_data(32'h1111_0002));                  // now in cycle 3
    tick();                                                // cycle 4: ISSUE A1
    check("rr_a1_waitreq", 64'(avs_waitrequest), 64'd0);
    wq.push_back({8'h20, 4'hF, 32'h2222_0002});
    avs_writedata = 32'h2222_0002;
    tick(); tick();                                        // cycle 6: ISSUE J2
    check("rr_j2_waitreq", 64'(avs_waitrequest), 64'd1);
    tick(); tick();                                        // cycle 8: ISSUE A2
    check("rr_a2_waitreq", 64'(avs_waitrequest), 64'd0);
    avs_write = 1'b0;
    tick();
    check("rr_ready", 64'(monitor_ready), 64'd1);
    check("rr_no_overrun", 64'(jtag_overrun), 64'd0);
    check("rr_writes_seen", 64'(wq.size()), 64'd0);

    // Overrun: second strobe while AVS holds the RAM and the slot is full
    strobe(K_A, jdo_ptr(8'hFE, 1'b0, 1'b0));
    aq.push_back(32'h0000_5678);
    avs_address = 8'h10; avs_read = 1'b1;
    tick();                                                // cycle 1: ISSUE AVS
    jq.push_back(32'hA5A5_0001);
    take_no_action_ocimem_a = 1'b1;                        // accepted
    tick();                                                // cycle 2: RDWAIT AVS
    check("ovr_avs_waitreq", 64'(avs_waitrequest), 64'd0);
    check("ovr_avs_data", 64'(avs_readdata), 64'(aq.pop_front()));
    avs_read = 1'b0;                                       // strobe still high: dropped
    tick();
    take_no_action_ocimem_a = 1'b0;
    check("ovr_flag_set", 64'(jtag_overrun), 64'd1);
    wait_ready("ovr_rd1_ready");
    check("ovr_rd1_data", 64'(MonDReg), 64'(jq.pop_front()));
    jq.push_back(32'hA5A5_0002);                           // pointer moved by one only
    strobe(K_NA, '0);
    wait_ready("ovr_rd2_ready");
    check("ovr_rd2_data", 64'(MonDReg), 64'(jq.pop_front()));
    check("ovr_flag_sticky", 64'(jtag_overrun), 64'd1);
    strobe(K_A, jdo_ptr(8'h00, 1'b0, 1'b1));
    check("ovr_flag_cleared", 64'(jtag_overrun), 64'd0);

    // Reset in the middle of an Avalon read with a JTAG op pending
    avs_address = 8'h10; avs_read = 1'b1;
    tick();                                                // ISSUE
    strobe(K_NA, '0);                                      // now in RDWAIT
    reset_n = 1'b0;
    #1;
    check("rst_rd_waitreq", 64'(avs_waitrequest), 64'd1);
    check("rst_rd_rdata", 64'(avs_readdata), 64'd0);
    avs_read = 1'b0;
    tick(); tick();
    check_reset_values("rst_rd");
    reset_n = 1'b1;
    tick();
    check("rst_rd_slot_dropped", 64'(monitor_ready), 64'd1);

    // Reset on the ISSUE cycle of an Avalon write: the write must not happen
    avs_address = 8'h30; avs_writedata = 32'hDEAD_BEEF; avs_byteenable = 4'hF; avs_write = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_wr_wren", 64'(ram_wren), 64'd0);
    check("rst_wr_waitreq", 64'(avs_waitrequest), 64'd1);
    avs_write = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    avs_rd("rst_wr_readback", 8'h30, 32'h0000_0000);

    tick(); tick();
    check("writes_drained", 64'(wq.size()), 64'd0);
    check("avs_reads_drained", 64'(aq.size()), 64'd0);
    check("jtag_reads_drained", 64'(jq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/camera_module_debug_mem_arbiter.md
# camera_module_debug_mem_arbiter

Single-port access arbiter and sequencer for the Nios II on-chip debug memory (256 x 32 OCI RAM). It shares the RAM between the JTAG debug command path (the `take_action_*` strobes and `jdo` bus from the debug slave's sysclk domain) and the CPU-side Avalon debug memory slave. It maintains the auto-incrementing JTAG address pointer and returns JTAG read data on `MonDReg`.

## Interface

No parameters. Address width 8 and data width 32 are fixed.

Ports are listed as name, direction, width, meaning:

- `clk` in 1: system clock. Single clock domain.
- `reset_n` in 1: reset, synchronous, active-low.
- `take_action_ocimem_a` in 1: pointer load / read command strobe.
- `take_action_ocimem_b` in 1: JTAG write command strobe.
- `take_no_action_ocimem_a` in 1: JTAG read-at-pointer command strobe.
- `jdo` in 38: JTAG command payload.
- `MonDReg` out 32: last JTAG read data.
- `monitor_ready` out 1: no JTAG op pending or in flight.
- `jtag_overrun` out 1: sticky flag; a JTAG command was dropped.
- `avs_address` in 8: Avalon debug slave word address.
- `avs_read`, `avs_write` in 1: Avalon request.
- `avs_writedata` in 32 / `avs_byteenable` in 4: Avalon write data and lane enables.
- `avs_readdata` out 32: Avalon read data.
- `avs_waitrequest` out 1: Avalon stall.
- `ram_addr` out 8, `ram_wren` out 1, `ram_byteen` out 4, `ram_wdata` out 32: RAM port.
- `ram_rdata` in 32: RAM read data, valid 1 cycle after address.

## Operation

- **JTAG command decode** (all strobes are 1-cycle pulses; at most one per cycle):
  - `take_action_ocimem_a`: pointer <= `jdo[17:10]`. If `jdo[34]`=1, also queue a read at the new pointer. If `jdo[35]`=1, clear `jtag_overrun`.
  - `take_action_ocimem_b`: queue a write of `jdo[34:3]` at the pointer, with byteen 4'hF.
  - `take_no_action_ocimem_a`: queue a read at the pointer.
- **Pending slot:** a single JTAG pending slot holds op type, address and data.
  - A strobe is accepted if the slot is empty or is being issued in the same cycle.
  - Otherwise the whole strobe is ignored (pointer unchanged) and `jtag_overrun` <= 1.
- **Pointer:** increments by 1 when its op issues; wraps 255 -> 0.
- **FSM states:** IDLE, ISSUE, RDWAIT.
  - IDLE -> ISSUE when the JTAG slot is pending or `avs_read|avs_write` is high.
    - If both are requesting, the grant goes to the requester not granted last (round-robin).
    - `last_grant` resets to AVS, so JTAG wins the first tie.
    - The granted requester and its op are latched.
  - ISSUE: drive `ram_addr`, `ram_wdata` and `ram_byteen`. `ram_wren` = 1 for writes. Clear the JTAG slot if JTAG owns the grant.
    - Write: next state IDLE.
    - Read: next state RDWAIT.
  - RDWAIT: `ram_rdata` is valid.
    - JTAG owner: `MonDReg` <= `ram_rdata`.
    - AVS owner: `avs_readdata` = `ram_rdata`.
    - Next state IDLE.
- **Avalon read/write priority:** if `avs_read` and `avs_write` are both high, the op is treated as a write.
- **Avalon stability:** the master holds its request stable while `avs_waitrequest`=1. The arbiter samples the Avalon request in IDLE only.

## Timing

- **Reset values:**
  - state IDLE, pointer 0, pending slot empty, `last_grant` AVS.
  - `MonDReg` 0, `monitor_ready` 1, `jtag_overrun` 0.
  - `ram_wren` 0, `ram_addr` 0, `ram_wdata` 0, `ram_byteen` 0.
  - `avs_waitrequest` 1, `avs_readdata` 0.
- **Avalon write:** request seen in IDLE at cycle 0. Cycle 1 (ISSUE): `ram_wren`=1 and `avs_waitrequest`=0; the write completes.
- **Avalon read:** cycle 1 ISSUE, cycle 2 RDWAIT with `avs_waitrequest`=0 and `avs_readdata` valid.
- **`avs_waitrequest`:** 1 in every other cycle, including when no request is present. `avs_readdata` is 0 outside an AVS RDWAIT.
- **JTAG timing:** strobe at cycle 0 fills the slot at cycle 1.
  - Earliest ISSUE at cycle 2.
  - For reads, `MonDReg` is updated at the end of cycle 3.
- **`monitor_ready`:** 0 from the cycle after an accepted strobe until the cycle after the JTAG op's ISSUE (write) or RDWAIT (read).
- **Throughput:** one op per 2 cycles (write) or 3 cycles (read). The FSM always returns to IDLE before re-arbitrating.
- **Contention:** under continuous contention, grants alternate strictly JTAG/AVS.
- **Reset mid-op:** a synchronous reset abandons the op.
  - No RAM write occurs in the reset cycle.
  - An Avalon master stalled at reset sees `avs_waitrequest`=1 and must reissue.

## Test plan

- **Reset check:** assert `reset_n`=0 for 2 cycles mid-read. All outputs are at reset values the next cycle, `ram_wren` never pulses, and `avs_waitrequest`=1.
- **JTAG write/read with auto-increment:** `take_action_ocimem_a` with `jdo[17:10]`=8'hFE, then `take_action_ocimem_b` twice with data 32'hA5A5_0001 and 32'hA5A5_0002. RAM[0xFE]/RAM[0xFF] are written and the pointer wraps to 0x00. Load 0xFE with `jdo[34]`=1: `MonDReg`=32'hA5A5_0001 at the 4th cycle.
- **Avalon latency:** Avalon write to 0x10 with byteenable 4'b0011 -> `avs_waitrequest` low exactly in cycle 1 with `ram_byteen`=4'b0011. Avalon read of 0x10 -> `avs_waitrequest` low in cycle 2 with matching data.
- **Arbitration:** `avs_read` and a JTAG read are both pending from reset. JTAG is issued first, then AVS. Sustained dual requests produce grant order J,A,J,A.
- **Overrun:** two `take_no_action_ocimem_a` strobes while an AVS read holds the RAM. The second is dropped, `jtag_overrun`=1 and the pointer advances by 1 only. `take_action_ocimem_a` with `jdo[35]`=1 clears `jtag_overrun`.
- **Same-cycle accept:** a JTAG strobe in the same cycle as the pending JTAG op's ISSUE is accepted with no overrun, and both ops complete in order.
